// File: rtl/controle_turno_tiro.sv
// controle_turno_tiro: naval-battle turn/shot controller with key edge detection, PvP/CPU turns and winner detection
module controle_turno_tiro #(
  parameter int COORD_W   = 4,
  parameter int BOARD_MAX = 9,
  parameter int PECAS_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 select_n,
  input  logic                 enter_n,
  input  logic                 mode,
  input  logic [2*COORD_W-1:0] posicao_rnd,
  input  logic                 acertou_tiro,
  input  logic [PECAS_W-1:0]   qtd_P1,
  input  logic [PECAS_W-1:0]   qtd_P2,
  output logic                 ready,
  output logic [COORD_W-1:0]   coord_tiroX,
  output logic [COORD_W-1:0]   coord_tiroY,
  output logic                 tiro_valid,
  output logic                 jogador,
  output logic [1:0]           vencedor,
  output logic [7:0]           LEDR,
  output logic [7:0]           LEDG
);
  typedef enum logic [2:0] {IDLE, SEL_X, SEL_Y, SHOOT, CHECK, RESULT, FIM} state_t;
  localparam logic [COORD_W-1:0] MAXC = COORD_W'(BOARD_MAX);
  localparam logic [COORD_W-1:0] SPAN = COORD_W'(BOARD_MAX + 1);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  state_t state, state_n;
  logic sel_q, ent_q, sel_ev, ent_ev, jog, jog_n, hit, hit_n, cpu, opp_zero;
  logic [COORD_W-1:0] x, y, x_n, y_n, rnd_x, rnd_y, raw_x, raw_y;
  logic [1:0] venc, venc_n;
  assign raw_x = posicao_rnd[COORD_W-1:0];
  assign raw_y = posicao_rnd[2*COORD_W-1:COORD_W];
  // Out-of-board random fields fold back onto the board by one board width
  assign rnd_x = raw_x > MAXC ? raw_x - SPAN : raw_x;
  assign rnd_y = raw_y > MAXC ? raw_y - SPAN : raw_y;
  assign cpu = !mode && jog;
  assign opp_zero = jog ? qtd_P1 == '0 : qtd_P2 == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      jog    <= 1'b0;
      hit    <= 1'b0;
      venc   <= 2'b00;
      sel_q  <= 1'b1;
      ent_q  <= 1'b1;
      sel_ev <= 1'b0;
      ent_ev <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      jog    <= jog_n;
      hit    <= hit_n;
      venc   <= venc_n;
      sel_q  <= select_n;
      ent_q  <= enter_n;
      sel_ev <= enable && sel_q && !select_n;
      ent_ev <= enable && ent_q && !enter_n;
    end
  end
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    jog_n   = jog;
    hit_n   = hit;
    venc_n  = venc;
    if (enable)
      case (state)
        IDLE: state_n = SEL_X;
        SEL_X:
          if (cpu) begin
            x_n     = rnd_x;
            y_n     = rnd_y;
            state_n = SHOOT;
          end else if (ent_ev) state_n = SEL_Y;
          else if (sel_ev) x_n = x == MAXC ? '0 : x + ONE;
        SEL_Y:
          if (ent_ev) state_n = SHOOT;
          else if (sel_ev) y_n = y == MAXC ? '0 : y + ONE;
        SHOOT: state_n = CHECK;
        CHECK: begin
          hit_n   = acertou_tiro;
          state_n = RESULT;
        end
        RESULT:
          if (ent_ev && opp_zero) begin
            venc_n  = jog ? 2'b10 : 2'b01;
            state_n = FIM;
          end else if (ent_ev) begin
            jog_n   = hit ? jog : !jog;
            x_n     = '0;
            y_n     = '0;
            state_n = SEL_X;
          end
        default: ;
      endcase
  end
  always_comb begin
    ready      = state == RESULT;
    tiro_valid = enable && state == SHOOT;
    LEDR       = state == RESULT ? {8{!hit}} : state == FIM ? {8{venc[1]}} : 8'h00;
    LEDG       = state == RESULT ? {8{hit}} : state == FIM ? {8{venc[0]}} :
                 {6'b0, state == SEL_Y, state == SEL_X};
  end
  assign coord_tiroX = x;
  assign coord_tiroY = y;
  assign jogador     = jog;
  assign vencedor    = venc;
endmodule

// File: doc/controle_turno_tiro.md
Name: controle_turno_tiro

Overview:
- Parametrised turn/shot controller for the naval-battle game.
- Board size, coordinate width and piece-count width are parameters.
- Adds features absent from the fixed single-turn executor: button edge detection, alternating turns between P1 and P2, a CPU opponent mode fed from the random source, and winner detection.
- Sits between the debounced DE2 keys, the board memory (hit lookup and piece counters) and the LED outputs.

Parameters:
- COORD_W, 4: width of each shot coordinate.
- BOARD_MAX, 9: highest legal coordinate value; board is (BOARD_MAX+1)². Constraint: BOARD_MAX >= 2^(COORD_W-1)-1.
- PECAS_W, 4: width of the remaining-pieces counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = controller runs; 0 = all state and outputs hold.
- select_n  in  1  active-low key; each press increments the coordinate being edited.
- enter_n  in  1  active-low key; each press confirms or acknowledges.
- mode  in  1  1 = player vs player; 0 = player vs CPU (P2 is CPU).
- posicao_rnd  in  2*COORD_W  CPU shot as {Y,X}.
- acertou_tiro  in  1  board lookup result: 1 = hit.
- qtd_P1  in  PECAS_W  P1 pieces remaining.
- qtd_P2  in  PECAS_W  P2 pieces remaining.
- ready  out  1  high while a shot result is displayed.
- coord_tiroX  out  COORD_W  current X coordinate.
- coord_tiroY  out  COORD_W  current Y coordinate.
- tiro_valid  out  1  one-cycle pulse requesting a board lookup at (X,Y).
- jogador  out  1  0 = P1's turn, 1 = P2's turn.
- vencedor  out  2  00 = none, 01 = P1 wins, 10 = P2 wins.
- LEDR  out  8  red LEDs.
- LEDG  out  8  green LEDs.

Behaviour:
- Reset (synchronous, dominates enable):
  - state = IDLE; X = Y = 0; jogador = 0; vencedor = 00.
  - ready = 0, tiro_valid = 0, LEDR = LEDG = 0.
  - Key history registers = 1 (released).
  - Reset applied mid-game aborts the game, including from FIM.
- Key events:
  - A press is a registered falling edge: previous key value = 1 and current value = 0.
  - Event is usable in the cycle after the edge; exactly one event per press, however long the key is held.
  - Key history updates every cycle, even when enable = 0. Events that occur while enable = 0 are discarded.
- enable = 0: state, coordinates and outputs hold, except tiro_valid, which is forced to 0.
- IDLE: on enable → SEL_X.
- SEL_X:
  - select event: X = (X == BOARD_MAX) ? 0 : X+1 (wraps).
  - enter event: → SEL_Y.
  - select and enter in the same cycle: enter wins; X is not incremented.
- SEL_Y: same rules applied to Y; enter event → SHOOT.
- CPU turn (mode = 0 and jogador = 1):
  - In SEL_X, keys are ignored.
  - Next cycle: X and Y load from posicao_rnd, then → SHOOT.
  - Each field > BOARD_MAX is reduced by (BOARD_MAX+1), so 4'd12 becomes 2.
- SHOOT: tiro_valid = 1 for exactly this cycle; → CHECK.
- CHECK:
  - acertou_tiro is sampled here, one cycle after tiro_valid, and latched as hit.
  - → RESULT.
- RESULT:
  - ready = 1.
  - LEDG = 8'hFF if hit; LEDR = 8'hFF if miss; the other LED bank = 0.
  - On enter event (also required on CPU turns):
    - If the opponent's count is 0 (qtd_P2 when jogador = 0, qtd_P1 when jogador = 1): → FIM; vencedor = jogador+1.
    - Else if hit: jogador is unchanged (extra shot).
    - Else: jogador toggles.
    - In both non-FIM cases X = Y = 0 and → SEL_X.
  - The opponent count is checked only at the enter event; a count that reaches 0 earlier has no effect until then.
- FIM:
  - ready = 0.
  - P1 wins: LEDG = 8'hFF, LEDR = 0. P2 wins: LEDR = 8'hFF, LEDG = 0.
  - Keys ignored; held until reset.
- Outside RESULT and FIM: LEDR = 0; LEDG = {6'b0, state == SEL_Y, state == SEL_X}.
- coord_tiroX and coord_tiroY are driven directly from their registers.

Test Plan:
- PvP, default parameters: 2 select presses, enter, 1 select press, enter, acertou_tiro = 1 → X = 2, Y = 1; tiro_valid is a single pulse; ready = 1; LEDG = FF; enter → jogador stays 0, X = Y = 0, state SEL_X.
- Wrap and priority: 10 select presses in SEL_X → X = 0. Simultaneous select and enter → X unchanged, state SEL_Y. Key held low for 20 cycles → exactly one increment.
- Miss: acertou_tiro = 0 → LEDR = FF, LEDG = 0; enter → jogador = 1.
- CPU turn: mode = 0, jogador = 1, posicao_rnd = 8'hC3 → X = 3, Y = 2 (12 reduced to 2) with no key presses; tiro_valid pulses within 2 cycles of entering SEL_X.
- Win: P1 hit with qtd_P2 = 0; enter → vencedor = 01, LEDG = FF, ready = 0. Further keys produce no change. reset → all outputs 0, state IDLE.
- enable = 0 during SEL_Y with select pressed → Y unchanged. Re-enable while the key is still held → no increment.
